// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the 5-stage pipeline sequencing logic:
//   controller state encoding, forwarding-select codes, register and
//   opcode constants, and the per-operand forwarding select function.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Youngest producer wins: EX/MEM result is newer than MEM/WB.
    // $0 is hard-wired, so it never forwards.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic       mem_rw,
        input logic [4:0] mem_wreg,
        input logic       wb_rw,
        input logic [4:0] wb_wreg
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != REG_ZERO) begin
            if (mem_rw && (mem_wreg == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_rw && (wb_wreg == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// fwd_unit
//   Combinational EX-stage forwarding selects for ALU operands A and B.
//   Ports:
//     ex_rs_i, ex_rt_i         source registers of the instruction in EX
//     mem_regwrite_i/_wreg_i   pending write in EX/MEM
//     wb_regwrite_i/_wreg_i    pending write in MEM/WB
//     fwd_a_o, fwd_b_o         00 regfile, 01 EX/MEM, 10 MEM/WB
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] mem_wreg_i,
    input  logic       wb_regwrite_i,
    input  logic [4:0] wb_wreg_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    assign fwd_a_o = fwd_pick(ex_rs_i, mem_regwrite_i, mem_wreg_i,
                              wb_regwrite_i, wb_wreg_i);
    assign fwd_b_o = fwd_pick(ex_rt_i, mem_regwrite_i, mem_wreg_i,
                              wb_regwrite_i, wb_wreg_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. Produces per-stage
//   register enables and flushes, load-use stalls, forwarding selects,
//   data-memory busy freeze and the halt drain sequence.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     id_*                        source fields / halt flag of ID instruction
//     ex_*                        sources, destination and controls of EX
//     mem_*, wb_*                 pending writes; mem_redirect = taken
//                                 branch/jump resolved in MEM
//     dmem_busy                   data memory not ready this cycle
//     pc_en .. memwb_en, *_flush  stage enables and bubble inserts
//     fwd_a, fwd_b                ALU operand selects
//     halted                      halt has retired
//     stall_cnt                   saturating count of pc_en=0 cycles
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | normal issue; stalls/redirects/halt detection active
//   ST_DRAIN  | halt left ID; fetch blocked while older work retires
//   ST_HALTED | halt retired in WB; everything frozen until reset
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_wreg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_redirect,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_wreg,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    pipe_state_e      state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_inc;
    logic             load_use;
    logic [1:0]       fwd_a_w, fwd_b_w;

    // Load-use detection only needs MemRead; RegWrite of the EX
    // instruction is implied for a load and not otherwise consulted.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    assign load_use = ex_memread && (ex_wreg != REG_ZERO) &&
                      ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

    fwd_unit u_fwd (
        .ex_rs_i        (ex_rs),
        .ex_rt_i        (ex_rt),
        .mem_regwrite_i (mem_regwrite),
        .mem_wreg_i     (mem_wreg),
        .wb_regwrite_i  (wb_regwrite),
        .wb_wreg_i      (wb_wreg),
        .fwd_a_o        (fwd_a_w),
        .fwd_b_o        (fwd_b_w)
    );

    // Forward selects are pure functions of the EX/MEM/WB fields, which
    // the freeze already holds steady; they are only masked during reset.
    assign fwd_a = rst ? FWD_RF : fwd_a_w;
    assign fwd_b = rst ? FWD_RF : fwd_b_w;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_inc   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        halted      = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN, ST_DRAIN: begin
                    if (dmem_busy) begin
                        stall_inc = 1'b1;
                    end else if (mem_redirect) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        // A halt seen during drain was on the wrong path.
                        state_d     = ST_RUN;
                        drain_d     = '0;
                    end else if (state_q == ST_DRAIN) begin
                        // ID only ever holds bubbles here, so load-use and
                        // a further halt are not considered.
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                        drain_d    = drain_q - DW'(1);
                        if (drain_q == DW'(1)) begin
                            state_d = ST_HALTED;
                        end
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (id_halt) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                        state_d    = ST_DRAIN;
                        drain_d    = DW'(DRAIN_CYCLES);
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ?
                         stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int DRAIN = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic             id_uses_rt, id_halt, ex_regwrite, ex_memread;
    logic             mem_regwrite, mem_redirect, wb_regwrite, dmem_busy;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, exmem_flush, memwb_en, halted;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg), .mem_redirect(mem_redirect),
        .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .dmem_busy(dmem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles of drain left (0 = running), halted flag,
    // and stall count as a plain integer.
    int  m_drain;
    bit  m_halted;
    int  m_stall;
    logic [4:0] e_en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] e_fl;   // {ifid, idex, exmem}
    bit  e_inc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (mem_regwrite && mem_wreg == src) return 2'b01;
        if (wb_regwrite && wb_wreg == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return ex_memread && ex_wreg != 5'd0 &&
               (ex_wreg == id_rs || (id_uses_rt && ex_wreg == id_rt));
    endfunction

    task automatic model_eval();
        e_en = 5'b00000; e_fl = 3'b000; e_inc = 0;
        if (m_halted) begin
        end else if (dmem_busy) begin
            e_inc = 1;
        end else if (mem_redirect) begin
            e_en = 5'b11111; e_fl = 3'b111;
        end else if (m_drain > 0) begin
            e_en = 5'b01111; e_fl = 3'b100; e_inc = 1;
        end else if (ref_lu()) begin
            e_en = 5'b00111; e_fl = 3'b010; e_inc = 1;
        end else if (id_halt) begin
            e_en = 5'b01111; e_fl = 3'b100; e_inc = 1;
        end else begin
            e_en = 5'b11111;
        end
    endtask

    task automatic model_update();
        if (e_inc && m_stall < SAT) m_stall++;
        if (!m_halted && !dmem_busy) begin
            if (mem_redirect) m_drain = 0;
            else if (m_drain > 0) begin
                if (m_drain == 1) m_halted = 1;
                m_drain--;
            end else if (!ref_lu() && id_halt) m_drain = DRAIN;
        end
    endtask

    task automatic check_comb();
        #1;
        model_eval();
        check("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e_en);
        check("flushes", {ifid_flush, idex_flush, exmem_flush}, e_fl);
        check("fwd_a", fwd_a, ref_fwd(ex_rs));
        check("fwd_b", fwd_b, ref_fwd(ex_rt));
        check("halted_comb", halted, m_halted);
    endtask

    task automatic step();
        check_comb();
        @(posedge clk);
        #1;
        model_update();
        check("stall_cnt", stall_cnt, m_stall);
        check("halted", halted, m_halted);
    endtask

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_halt = 0;
        ex_rs = 0; ex_rt = 0; ex_regwrite = 0; ex_memread = 0; ex_wreg = 0;
        mem_regwrite = 0; mem_wreg = 0; mem_redirect = 0;
        wb_regwrite = 0; wb_wreg = 0; dmem_busy = 0;
    endtask

    // Called at posedge+1; asserts reset between edges and checks that
    // outputs and counter clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
        check("rst_fl", {ifid_flush, idex_flush, exmem_flush}, 3'b000);
        check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("rst_halted", halted, 1'b0);
        check("rst_stall", stall_cnt, 0);
        m_drain = 0; m_halted = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        do_reset();
        step();

        // load-use: one bubble, then free-running
        ex_memread = 1; ex_wreg = 5; id_rs = 5;
        #1;
        check("lu_pc_en", pc_en, 1'b0);
        check("lu_idex_flush", idex_flush, 1'b1);
        step();
        ex_memread = 0;
        step();
        check("lu_stall_cnt", stall_cnt, 1);

        // forwarding priority
        set_idle();
        ex_rs = 7; ex_rt = 7; mem_wreg = 7; wb_wreg = 7; mem_regwrite = 1; wb_regwrite = 1;
        #1; check("fwd_exmem", fwd_a, 2'b01);
        step();
        mem_regwrite = 0;
        #1; check("fwd_memwb", fwd_a, 2'b10);
        step();
        ex_rs = 0; ex_rt = 0; mem_wreg = 0; wb_wreg = 0; mem_regwrite = 1;
        #1; check("fwd_zero", {fwd_a, fwd_b}, 4'b0000);
        step();

        // redirect beats load-use
        set_idle();
        ex_memread = 1; ex_wreg = 3; id_rt = 3; id_uses_rt = 1; mem_redirect = 1;
        #1;
        check("redir_pc_en", pc_en, 1'b1);
        check("redir_idex_en", idex_en, 1'b1);
        check("redir_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        step();

        // halt drain
        set_idle();
        do_reset();
        id_halt = 1;
        step();
        id_halt = 0;
        for (int k = 2; k <= 4; k++) begin
            step();
            check("drain_halted", halted, (k >= 4));
        end
        check("drain_stall_cnt", stall_cnt, 4);
        step();
        check("halted_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);

        // busy mid-drain delays halt by two cycles
        do_reset();
        id_halt = 1; step(); id_halt = 0;
        step();
        dmem_busy = 1;
        #1; check("busy_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
        step(); step();
        dmem_busy = 0;
        step();
        check("busy_not_yet", halted, 1'b0);
        step();
        check("busy_halted", halted, 1'b1);
        check("busy_stall_cnt", stall_cnt, 6);

        // redirect during drain returns to RUN
        do_reset();
        id_halt = 1; step(); id_halt = 0;
        mem_redirect = 1; step(); mem_redirect = 0;
        #1; check("redir_drain_run", pc_en, 1'b1);
        step();

        // saturation and async mid-cycle reset
        do_reset();
        ex_memread = 1; ex_wreg = 9; id_rs = 9;
        for (int k = 0; k < 20; k++) step();
        check("sat_stall_cnt", stall_cnt, SAT);
        do_reset();
        set_idle();
        step();

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            id_halt      = ($urandom_range(0, 99) < 4);
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 99) < 40);
            ex_wreg      = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_wreg     = 5'($urandom_range(0, 3));
            mem_redirect = ($urandom_range(0, 99) < 10);
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_wreg      = 5'($urandom_range(0, 3));
            dmem_busy    = ($urandom_range(0, 99) < 20);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
